// File: rtl/kmac_pkg.sv
// Shared types and defaults for the KMAC message path.
// Holds the flush FSM encoding and the default message word width.
package kmac_pkg;

    localparam int MsgWidth = 64;

    typedef enum logic [1:0] {
        FlushIdle       = 2'd0,
        FlushWaitPacker = 2'd1,
        FlushDrain      = 2'd2,
        FlushDone       = 2'd3
    } flush_st_e;

endpackage

// File: rtl/kmac_msg_fifo_fsm.sv
// End-of-message flush sequencer for the KMAC message FIFO.
// Asks the packer to flush, waits for it, then waits for the FIFO to drain.
module kmac_msg_fifo_fsm
    import kmac_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic flush_i,
    input  logic packer_flush_done_i,
    input  logic empty_i,
    output logic packer_flush_o,
    output logic flush_done_o,
    output logic idle_o
);

    flush_st_e state_q, state_d;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FlushIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; clear wins over every transition
    always_comb begin
        state_d        = state_q;
        packer_flush_o = 1'b0;
        flush_done_o   = 1'b0;
        idle_o         = 1'b0;
        unique case (state_q)
            FlushIdle: begin
                idle_o = 1'b1;
                if (flush_i) state_d = FlushWaitPacker;
            end
            FlushWaitPacker: begin
                packer_flush_o = 1'b1;
                if (packer_flush_done_i) state_d = FlushDrain;
            end
            FlushDrain: begin
                if (empty_i) state_d = FlushDone;
            end
            FlushDone: begin
                flush_done_o = 1'b1;
                state_d      = FlushIdle;
            end
            default: state_d = FlushIdle;
        endcase
        if (clr_i) state_d = FlushIdle;
    end

endmodule

// File: rtl/kmac_msg_fifo.sv
// First-word-fall-through buffer between the byte packer and Keccak absorb.
// Also flags partial words that arrive outside an end-of-message flush.
module kmac_msg_fifo
    import kmac_pkg::*;
#(
    parameter int Width  = MsgWidth,
    parameter int Depth  = 8,
    parameter int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [Width-1:0]  data_i,
    input  logic [Width-1:0]  mask_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [Width-1:0]  data_o,
    output logic [Width-1:0]  mask_o,
    input  logic              ready_i,
    input  logic              clr_i,
    input  logic              flush_i,
    output logic              packer_flush_o,
    input  logic              packer_flush_done_i,
    output logic              flush_done_o,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] CntFull = DepthW'(Depth);

    logic [Width-1:0]  data_q [Depth];
    logic [Width-1:0]  data_d [Depth];
    logic [Width-1:0]  mask_q [Depth];
    logic [Width-1:0]  mask_d [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [DepthW-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              push, pop, fsm_idle;

    assign full_o  = (cnt_q == CntFull);
    assign empty_o = (cnt_q == '0);
    assign ready_o = !full_o;
    assign valid_o = !empty_o;
    assign depth_o = cnt_q;
    assign err_o   = err_q;
    assign data_o  = empty_o ? '0 : data_q[rptr_q];
    assign mask_o  = empty_o ? '0 : mask_q[rptr_q];

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // Storage, pointers, occupancy and sticky error next-state
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
        end else begin
            if (push) begin
                data_d[wptr_q] = data_i;
                mask_d[wptr_q] = mask_i;
                wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
                if (fsm_idle && (mask_i != '1)) err_d = 1'b1;
            end
            if (pop) begin
                rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
            end
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    kmac_msg_fifo_fsm u_fsm (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .clr_i               (clr_i),
        .flush_i             (flush_i),
        .packer_flush_done_i (packer_flush_done_i),
        .empty_i             (empty_o),
        .packer_flush_o      (packer_flush_o),
        .flush_done_o        (flush_done_o),
        .idle_o              (fsm_idle)
    );

endmodule

// File: tb/tb_kmac_msg_fifo.sv
// Scoreboard bench for kmac_msg_fifo.
// Monitor holds a queue-level reference model and checks every cycle.
module tb_kmac_msg_fifo;

    localparam int W = 64;
    localparam int D = 8;
    localparam int DW = $clog2(D + 1);

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] m;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i, ready_i, clr_i, flush_i, pdone_i;
    logic [W-1:0]  data_i, mask_i;
    logic          ready_o, valid_o, pflush_o, fdone_o;
    logic          full_o, empty_o, err_o;
    logic [W-1:0]  data_o, mask_o;
    logic [DW-1:0] depth_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model state
    ent_t exp_q[$];
    bit   m_err;
    // flush progress: 0 idle, 1 waiting on packer, 2 draining, 3 done
    int   m_ph;

    always #5 clk = ~clk;

    kmac_msg_fifo #(.Width(W), .Depth(D)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .valid_i             (valid_i),
        .data_i              (data_i),
        .mask_i              (mask_i),
        .ready_o             (ready_o),
        .valid_o             (valid_o),
        .data_o              (data_o),
        .mask_o              (mask_o),
        .ready_i             (ready_i),
        .clr_i               (clr_i),
        .flush_i             (flush_i),
        .packer_flush_o      (pflush_o),
        .packer_flush_done_i (pdone_i),
        .flush_done_o        (fdone_o),
        .depth_o             (depth_o),
        .full_o              (full_o),
        .empty_o             (empty_o),
        .err_o               (err_o)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Monitor: compare outputs to the model, then advance the model
    always @(negedge clk) begin
        int  sz;
        bit  can_push, do_pop;
        ent_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_err = 0;
            m_ph  = 0;
        end
        sz = exp_q.size();
        chk("valid_o", W'(valid_o), W'(sz != 0));
        chk("empty_o", W'(empty_o), W'(sz == 0));
        chk("full_o",  W'(full_o),  W'(sz == D));
        chk("ready_o", W'(ready_o), W'(sz < D));
        chk("depth_o", W'(depth_o), W'(sz));
        chk("err_o",   W'(err_o),   W'(m_err));
        chk("packer_flush_o", W'(pflush_o), W'(m_ph == 1));
        chk("flush_done_o",   W'(fdone_o),  W'(m_ph == 3));
        if (sz != 0) begin
            chk("data_o", data_o, exp_q[0].d);
            chk("mask_o", mask_o, exp_q[0].m);
        end else begin
            chk("data_o_empty", data_o, '0);
            chk("mask_o_empty", mask_o, '0);
        end
        if (rst_n) begin
            if (clr_i) begin
                exp_q.delete();
                m_err = 0;
                m_ph  = 0;
            end else begin
                can_push = valid_i && (sz < D);
                do_pop   = ready_i && (sz != 0);
                if (can_push && m_ph == 0 && mask_i != {W{1'b1}})
                    m_err = 1;
                if (do_pop) void'(exp_q.pop_front());
                if (can_push) begin
                    e.d = data_i;
                    e.m = mask_i;
                    exp_q.push_back(e);
                end
                case (m_ph)
                    0: if (flush_i) m_ph = 1;
                    1: if (pdone_i) m_ph = 2;
                    2: if (sz == 0) m_ph = 3;
                    default: m_ph = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid_i = 0;
        clr_i   = 0;
        flush_i = 0;
        pdone_i = 0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (fdone_o) seen = 1;
        end
        chk(name, W'(seen), W'(1));
    endtask

    task automatic drain();
        idle_in();
        ready_i = 1;
        for (int i = 0; i < D + 4; i++) step();
    endtask

    initial begin
        logic [W-1:0] full_m;
        full_m  = '1;
        rst_n   = 0;
        ready_i = 0;
        data_i  = '0;
        mask_i  = '0;
        idle_in();
        repeat (3) step();
        rst_n = 1;
        step();

        // three full words, nothing consumed
        mask_i  = full_m;
        valid_i = 1;
        data_i  = 64'h1111_1111_1111_1111; step();
        data_i  = 64'h2222_2222_2222_2222; step();
        data_i  = 64'h3333_3333_3333_3333; step();
        valid_i = 0;
        step();
        chk("depth_after3", W'(depth_o), W'(3));
        chk("head_after3", data_o, 64'h1111_1111_1111_1111);

        // fill to full, then push+pop while full
        valid_i = 1;
        for (int i = 4; i <= D; i++) begin
            data_i = {16{4'(i)}};
            step();
        end
        chk("full_reached", W'(full_o), W'(1));
        data_i  = 64'hDEAD_BEEF_0000_0001;
        ready_i = 1;
        step();
        valid_i = 0;
        ready_i = 0;
        chk("depth_after_full_pop", W'(depth_o), W'(D - 1));
        chk("ready_after_full_pop", W'(ready_o), W'(1));
        drain();

        // random traffic across pointer wraps
        for (int i = 0; i < 60; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = {$urandom, $urandom};
            mask_i  = full_m;
            step();
        end
        drain();

        // flush with two words queued
        ready_i = 0;
        valid_i = 1;
        data_i  = 64'hA5A5_0000_0000_0001; step();
        data_i  = 64'hA5A5_0000_0000_0002; step();
        valid_i = 0;
        flush_i = 1;
        ready_i = 1;
        step();
        flush_i = 0;
        repeat (2) step();
        pdone_i = 1;
        step();
        pdone_i = 0;
        wait_done("flush_done_2words");
        step();

        // empty-FIFO flush, done pulse right away
        flush_i = 1; step();
        flush_i = 0; pdone_i = 1; step();
        pdone_i = 0;
        wait_done("flush_done_empty");
        step();

        // partial mask in idle sets sticky error
        ready_i = 0;
        valid_i = 1;
        data_i  = 64'h0123;
        mask_i  = 64'h00FF;
        step();
        valid_i = 0;
        mask_i  = full_m;
        repeat (2) step();
        chk("err_sticky", W'(err_o), W'(1));
        clr_i = 1; step();
        clr_i = 0; step();
        chk("err_cleared", W'(err_o), W'(0));
        chk("depth_cleared", W'(depth_o), W'(0));

        // partial mask during flush is legal
        flush_i = 1; step();
        flush_i = 0;
        valid_i = 1;
        data_i  = 64'h4567;
        mask_i  = 64'h00FF;
        step();
        valid_i = 0;
        mask_i  = full_m;
        chk("err_in_flush", W'(err_o), W'(0));
        pdone_i = 1; step();
        pdone_i = 0;
        ready_i = 1;
        wait_done("flush_done_partial");
        drain();

        // async reset while draining with four entries
        ready_i = 0;
        valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            data_i = {$urandom, $urandom};
            step();
        end
        valid_i = 0;
        flush_i = 1; step();
        flush_i = 0; pdone_i = 1; step();
        pdone_i = 0; step();
        #2 rst_n = 0;
        #1;
        chk("rst_depth", W'(depth_o), W'(0));
        chk("rst_valid", W'(valid_o), W'(0));
        chk("rst_ready", W'(ready_o), W'(1));
        chk("rst_pflush", W'(pflush_o), W'(0));
        chk("rst_fdone", W'(fdone_o), W'(0));
        chk("rst_data", data_o, '0);
        repeat (2) step();
        rst_n = 1;
        repeat (10) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
